// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// State encoding, RV32I funct3 load/store encodings, byte-enable
// patterns and small helpers for access-size decoding.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  // RV32I funct3 encodings (stores reuse the signed-load codes)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Byte-enable patterns for lane 0, shifted by the address offset
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Anything not a byte or half encoding is handled as a word access
  function automatic lsu_size_e decode_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: decode_size = SZ_BYTE;
      F3_LH, F3_LHU: decode_size = SZ_HALF;
      default:       decode_size = SZ_WORD;
    endcase
  endfunction

  // True when the low address bits do not fit the natural alignment
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr);
    case (decode_size(f3))
      SZ_HALF: is_misaligned = addr[0];
      SZ_WORD: is_misaligned = |addr;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit: byte enables,
// store-data replication and load lane extraction with sign/zero extension.
// Half accesses look only at addr[1]; word accesses ignore the low bits.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  lsu_size_e   size;
  logic        sign_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign size     = decode_size(funct3_i);
  assign sign_ext = ~funct3_i[2];
  assign byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
  assign half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Byte enables: shift the lane-0 pattern to the addressed lane
  always_comb begin
    be_o = BE_WORD;
    case (size)
      SZ_BYTE: be_o = BE_BYTE << addr_i;
      SZ_HALF: be_o = BE_HALF << {addr_i[1], 1'b0};
      default: be_o = BE_WORD;
    endcase
  end

  // Store data replicated across lanes so any enabled lane sees its byte
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_o[8*gi +: 8] = (size == SZ_BYTE) ? wdata_i[7:0] :
                                  (size == SZ_HALF) ? wdata_i[8*(gi%2) +: 8] :
                                                      wdata_i[8*gi +: 8];
    end
  endgenerate

  // Load result: pick the addressed lane and extend to 32 bits
  always_comb begin
    load_o = rdata_i;
    case (size)
      SZ_BYTE: load_o = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_o = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: load_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE -> REQ -> DONE handshake with a timeout abort.
// One operation outstanding; the datapath is stalled until DONE.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses bypass
// the memory request and complete immediately with err=1.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ls_valid,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] aluresult,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [3:0]  be_al;
  logic [31:0] wdata_al;
  logic [31:0] load_al;
  logic [7:0]  cnt_inc;

  assign cnt_inc = cnt_q + 8'd1;

  lsu_align u_align (
    .funct3_i (funct3_q),
    .addr_i   (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rdata_i  (mem_rdata),
    .be_o     (be_al),
    .wdata_o  (wdata_al),
    .load_o   (load_al)
  );

  // State and captured-operation registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: accept, wait for memory or time out, one-cycle DONE
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (ls_valid) begin
          addr_d   = aluresult;
          wdata_d  = writedata;
          funct3_d = funct3;
          we_d     = memwrite;
          cnt_d    = '0;
          rdata_d  = '0;
          err_d    = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
          if (is_misaligned(funct3, aluresult[1:0])) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
`else
          state_d  = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        // A ready in the same cycle the counter would expire still succeeds
        if (mem_ready) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'd0 : load_al;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
          cnt_d   = cnt_inc;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory-side outputs are forced to zero whenever no request is active
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_be    = mem_req ? be_al : 4'd0;
  assign mem_wdata = mem_req ? wdata_al : 32'd0;

  assign done      = (state_q == ST_DONE);
  assign err       = done & err_q;
  assign readdata  = done ? rdata_q : 32'd0;
  assign stall     = ((state_q == ST_IDLE) & ls_valid) | mem_req;

endmodule
